// File: rtl/frontend_sweep_ctrl.sv
// Frequency-sweep sequencer: steps the frontend phase increment, waits for settling,
// captures sin/cos results and streams them out. Optional peak tracking: FRONTEND_SWEEP_PEAK_TRACK_EN.
module frontend_sweep_ctrl #(
    parameter int PHASE_INCREMENT_BITS = 28,
    parameter int MUL_ACC_WIDTH        = 32,
    parameter int COUNT_BITS           = 10,
    parameter int SETTLE_BITS          = 16
) (
    input  logic                            CLK,
    input  logic                            RESET_N,
    input  logic                            CE,
    input  logic                            START,
    input  logic                            ABORT,
    input  logic [PHASE_INCREMENT_BITS-1:0] CFG_START_INC,
    input  logic [PHASE_INCREMENT_BITS-1:0] CFG_STEP_INC,
    input  logic [COUNT_BITS-1:0]           CFG_POINTS,
    input  logic [SETTLE_BITS-1:0]          CFG_SETTLE,
    output logic [PHASE_INCREMENT_BITS-1:0] PHASE_INCREMENT_OUT,
    input  logic signed [MUL_ACC_WIDTH-1:0] SIN_MUL_ACC,
    input  logic signed [MUL_ACC_WIDTH-1:0] COS_MUL_ACC,
    output logic                            RES_VALID,
    input  logic                            RES_READY,
    output logic [COUNT_BITS-1:0]           RES_INDEX,
    output logic [PHASE_INCREMENT_BITS-1:0] RES_PHASE_INC,
    output logic signed [MUL_ACC_WIDTH-1:0] RES_SIN,
    output logic signed [MUL_ACC_WIDTH-1:0] RES_COS,
    output logic                            BUSY,
    output logic                            DONE
`ifdef FRONTEND_SWEEP_PEAK_TRACK_EN
    ,
    output logic [COUNT_BITS-1:0]           PEAK_INDEX,
    output logic [MUL_ACC_WIDTH:0]          PEAK_MAG
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_OUTPUT  = 2'd3
    } state_t;

    state_t                          state_r, state_s;
    logic [PHASE_INCREMENT_BITS-1:0] step_r;
    logic [COUNT_BITS-1:0]           points_r;
    logic [SETTLE_BITS-1:0]          settle_r;
    logic [SETTLE_BITS-1:0]          cnt_r;
    logic [COUNT_BITS-1:0]           idx_r;
    logic                            accept_s, empty_start_s, abort_s, transfer_s, last_s;

    assign accept_s      = CE & START & (state_r == ST_IDLE) & (CFG_POINTS != '0);
    assign empty_start_s = CE & START & (state_r == ST_IDLE) & (CFG_POINTS == '0);
    assign abort_s       = CE & ABORT & (state_r != ST_IDLE);
    assign transfer_s    = CE & RES_VALID & RES_READY & (state_r == ST_OUTPUT);
    assign last_s        = (idx_r == (points_r - COUNT_BITS'(1)));

    // State register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; abort outranks every other transition
    always_comb begin
        state_s = state_r;
        if (abort_s) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) state_s = ST_SETTLE;
                    else          state_s = ST_IDLE;
                end
                ST_SETTLE: begin
                    if (CE && (cnt_r == '0)) state_s = ST_CAPTURE;
                    else                     state_s = ST_SETTLE;
                end
                ST_CAPTURE: begin
                    if (CE) state_s = ST_OUTPUT;
                    else    state_s = ST_CAPTURE;
                end
                ST_OUTPUT: begin
                    if (transfer_s) state_s = last_s ? ST_IDLE : ST_SETTLE;
                    else            state_s = ST_OUTPUT;
                end
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // Output decode from state
    always_comb begin
        BUSY = 1'b0;
        if (state_r != ST_IDLE) BUSY = 1'b1;
        else                    BUSY = 1'b0;
    end

    // Datapath and registered result stream
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            step_r              <= '0;
            points_r            <= '0;
            settle_r            <= '0;
            cnt_r               <= '0;
            idx_r               <= '0;
            PHASE_INCREMENT_OUT <= '0;
            RES_VALID           <= 1'b0;
            RES_INDEX           <= '0;
            RES_PHASE_INC       <= '0;
            RES_SIN             <= '0;
            RES_COS             <= '0;
            DONE                <= 1'b0;
        end else if (CE) begin
            DONE <= 1'b0;
            if (abort_s) begin
                RES_VALID <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (accept_s) begin
                            step_r              <= CFG_STEP_INC;
                            points_r            <= CFG_POINTS;
                            settle_r            <= CFG_SETTLE;
                            cnt_r               <= CFG_SETTLE;
                            idx_r               <= '0;
                            PHASE_INCREMENT_OUT <= CFG_START_INC;
                        end else if (empty_start_s) begin
                            DONE <= 1'b1;
                        end
                    end
                    ST_SETTLE: begin
                        if (cnt_r != '0) cnt_r <= cnt_r - SETTLE_BITS'(1);
                    end
                    ST_CAPTURE: begin
                        RES_SIN       <= SIN_MUL_ACC;
                        RES_COS       <= COS_MUL_ACC;
                        RES_INDEX     <= idx_r;
                        RES_PHASE_INC <= PHASE_INCREMENT_OUT;
                        RES_VALID     <= 1'b1;
                    end
                    ST_OUTPUT: begin
                        if (transfer_s) begin
                            RES_VALID <= 1'b0;
                            if (last_s) begin
                                DONE <= 1'b1;
                            end else begin
                                idx_r               <= idx_r + COUNT_BITS'(1);
                                PHASE_INCREMENT_OUT <= PHASE_INCREMENT_OUT + step_r;
                                cnt_r               <= settle_r;
                            end
                        end
                    end
                    default: RES_VALID <= 1'b0;
                endcase
            end
        end
    end

`ifdef FRONTEND_SWEEP_PEAK_TRACK_EN
    // Magnitude of a two's-complement value; the most negative input still fits unsigned
    function automatic logic [MUL_ACC_WIDTH-1:0] abs_mag(input logic signed [MUL_ACC_WIDTH-1:0] v);
        if (v[MUL_ACC_WIDTH-1]) return MUL_ACC_WIDTH'(~v + 1'b1);
        else                    return MUL_ACC_WIDTH'(v);
    endfunction

    logic [MUL_ACC_WIDTH:0] mag_s;
    assign mag_s = {1'b0, abs_mag(SIN_MUL_ACC)} + {1'b0, abs_mag(COS_MUL_ACC)};

    // Peak tracker: strictly-greater update, first point of a sweep always loads
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            PEAK_INDEX <= '0;
            PEAK_MAG   <= '0;
        end else if (CE && !abort_s) begin
            if (accept_s) begin
                PEAK_INDEX <= '0;
                PEAK_MAG   <= '0;
            end else if ((state_r == ST_CAPTURE) && ((idx_r == '0) || (mag_s > PEAK_MAG))) begin
                PEAK_INDEX <= idx_r;
                PEAK_MAG   <= mag_s;
            end
        end
    end
`endif

endmodule

// File: tb/tb_frontend_sweep_ctrl.sv
// Directed self-checking bench for frontend_sweep_ctrl: sweep, backpressure, wrap,
// abort/restart, empty sweep, clock-enable stall and reset mid-sweep.
module tb_frontend_sweep_ctrl;

    logic               CLK = 1'b0;
    logic               RESET_N, CE, START, ABORT, RES_READY;
    logic [27:0]        CFG_START_INC, CFG_STEP_INC;
    logic [9:0]         CFG_POINTS;
    logic [15:0]        CFG_SETTLE;
    logic [27:0]        PHASE_INCREMENT_OUT, RES_PHASE_INC;
    logic signed [31:0] SIN_MUL_ACC, COS_MUL_ACC, RES_SIN, RES_COS;
    logic               RES_VALID, BUSY, DONE;
    logic [9:0]         RES_INDEX;
`ifdef FRONTEND_SWEEP_PEAK_TRACK_EN
    logic [9:0]         PEAK_INDEX;
    logic [32:0]        PEAK_MAG;
`endif

    int compared   = 0;
    int mismatched = 0;
    int n;
    logic signed [31:0] sin_v, cos_v;

    frontend_sweep_ctrl dut (
        .CLK(CLK), .RESET_N(RESET_N), .CE(CE), .START(START), .ABORT(ABORT),
        .CFG_START_INC(CFG_START_INC), .CFG_STEP_INC(CFG_STEP_INC),
        .CFG_POINTS(CFG_POINTS), .CFG_SETTLE(CFG_SETTLE),
        .PHASE_INCREMENT_OUT(PHASE_INCREMENT_OUT),
        .SIN_MUL_ACC(SIN_MUL_ACC), .COS_MUL_ACC(COS_MUL_ACC),
        .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_INDEX(RES_INDEX),
        .RES_PHASE_INC(RES_PHASE_INC), .RES_SIN(RES_SIN), .RES_COS(RES_COS),
        .BUSY(BUSY), .DONE(DONE)
`ifdef FRONTEND_SWEEP_PEAK_TRACK_EN
        , .PEAK_INDEX(PEAK_INDEX), .PEAK_MAG(PEAK_MAG)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Steps until RES_VALID is seen; cnt is the number of edges taken, 0 on timeout
    task automatic wait_valid(output int cnt);
        cnt = 0;
        for (int i = 1; i <= 100; i++) begin
            step();
            if (RES_VALID) begin
                cnt = i;
                break;
            end
        end
    endtask

    task automatic start_sweep(input logic [27:0] s_inc, input logic [27:0] st_inc,
                               input logic [9:0] pts, input logic [15:0] stl);
        CFG_START_INC = s_inc;
        CFG_STEP_INC  = st_inc;
        CFG_POINTS    = pts;
        CFG_SETTLE    = stl;
        START         = 1'b1;
        step();
        START         = 1'b0;
    endtask

    initial begin
        RESET_N = 1'b0; CE = 1'b1; START = 1'b0; ABORT = 1'b0; RES_READY = 1'b1;
        CFG_START_INC = '0; CFG_STEP_INC = '0; CFG_POINTS = '0; CFG_SETTLE = '0;
        sin_v = -32'sd7; cos_v = 32'sd9;
        SIN_MUL_ACC = sin_v; COS_MUL_ACC = cos_v;
        step(); step();
        check("rst_busy", BUSY, 64'd0);
        check("rst_valid", RES_VALID, 64'd0);
        check("rst_done", DONE, 64'd0);
        check("rst_phase", PHASE_INCREMENT_OUT, 64'd0);
        RESET_N = 1'b1;

        // Basic sweep: 1000/10, 3 points, settle 4
        start_sweep(28'd1000, 28'd10, 10'd3, 16'd4);
        check("basic_busy", BUSY, 64'd1);
        check("basic_phase0", PHASE_INCREMENT_OUT, 64'd1000);
        wait_valid(n);
        check("basic_lat0", n, 64'd6);
        check("basic_idx0", RES_INDEX, 64'd0);
        check("basic_pinc0", RES_PHASE_INC, 64'd1000);
        check("basic_sin0", RES_SIN, sin_v);
        check("basic_cos0", RES_COS, cos_v);
        wait_valid(n);
        check("basic_lat1", n, 64'd7);
        check("basic_idx1", RES_INDEX, 64'd1);
        check("basic_pinc1", RES_PHASE_INC, 64'd1010);
        wait_valid(n);
        check("basic_idx2", RES_INDEX, 64'd2);
        check("basic_pinc2", RES_PHASE_INC, 64'd1020);
        step();
        check("basic_done", DONE, 64'd1);
        check("basic_idle", BUSY, 64'd0);
        check("basic_valid_off", RES_VALID, 64'd0);
        check("basic_phase_hold", PHASE_INCREMENT_OUT, 64'd1020);
        step();
        check("basic_done_pulse", DONE, 64'd0);

        // Backpressure: 20 stalled cycles in OUTPUT with changing inputs
        RES_READY = 1'b0;
        start_sweep(28'd500, 28'd3, 10'd2, 16'd2);
        wait_valid(n);
        check("bp_lat", n, 64'd4);
        SIN_MUL_ACC = 32'sd1234; COS_MUL_ACC = -32'sd55;
        for (int i = 0; i < 20; i++) step();
        check("bp_valid", RES_VALID, 64'd1);
        check("bp_idx", RES_INDEX, 64'd0);
        check("bp_pinc", RES_PHASE_INC, 64'd500);
        check("bp_sin", RES_SIN, sin_v);
        check("bp_phase", PHASE_INCREMENT_OUT, 64'd500);
        RES_READY = 1'b1;
        step();
        check("bp_xfer_valid", RES_VALID, 64'd0);
        check("bp_xfer_phase", PHASE_INCREMENT_OUT, 64'd503);
        wait_valid(n);
        check("bp_lat1", n, 64'd4);
        check("bp_idx1", RES_INDEX, 64'd1);
        check("bp_sin1", RES_SIN, 64'sd1234);
        step();
        check("bp_done", DONE, 64'd1);
        SIN_MUL_ACC = sin_v; COS_MUL_ACC = cos_v;

        // Phase increment wraps modulo 2^28
        start_sweep(28'hFFF_FFFB, 28'd10, 10'd2, 16'd0);
        wait_valid(n);
        check("wrap_lat0", n, 64'd2);
        check("wrap_pinc0", RES_PHASE_INC, 64'h0FFF_FFFB);
        wait_valid(n);
        check("wrap_lat1", n, 64'd3);
        check("wrap_pinc1", RES_PHASE_INC, 64'd5);
        step();
        check("wrap_done", DONE, 64'd1);

        // Abort in SETTLE of point 1, START while busy ignored
        start_sweep(28'd100, 28'd1, 10'd3, 16'd5);
        wait_valid(n);
        check("ab_lat0", n, 64'd7);
        step();
        check("ab_phase1", PHASE_INCREMENT_OUT, 64'd101);
        start_sweep(28'd7777, 28'd1, 10'd9, 16'd0);
        check("ab_start_ignored", PHASE_INCREMENT_OUT, 64'd101);
        check("ab_still_busy", BUSY, 64'd1);
        ABORT = 1'b1;
        step();
        ABORT = 1'b0;
        check("ab_busy", BUSY, 64'd0);
        check("ab_valid", RES_VALID, 64'd0);
        check("ab_no_done", DONE, 64'd0);
        check("ab_phase_hold", PHASE_INCREMENT_OUT, 64'd101);
        step();
        check("ab_no_done2", DONE, 64'd0);
        start_sweep(28'd42, 28'd1, 10'd1, 16'd1);
        check("rs_phase", PHASE_INCREMENT_OUT, 64'd42);
        wait_valid(n);
        check("rs_lat", n, 64'd3);
        check("rs_idx", RES_INDEX, 64'd0);
        step();
        check("rs_done", DONE, 64'd1);

        // Empty sweep
        start_sweep(28'd999, 28'd1, 10'd0, 16'd3);
        check("empty_done", DONE, 64'd1);
        check("empty_busy", BUSY, 64'd0);
        check("empty_phase", PHASE_INCREMENT_OUT, 64'd42);
        step();
        check("empty_done_off", DONE, 64'd0);
        check("empty_valid", RES_VALID, 64'd0);

        // CE low for 10 cycles mid-SETTLE stretches latency by 10
        start_sweep(28'd300, 28'd1, 10'd1, 16'd3);
        step();
        CE = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("ce_frozen_busy", BUSY, 64'd1);
        check("ce_frozen_valid", RES_VALID, 64'd0);
        CE = 1'b1;
        wait_valid(n);
        check("ce_remaining_lat", n, 64'd4);
        step();
        check("ce_done", DONE, 64'd1);

`ifdef FRONTEND_SWEEP_PEAK_TRACK_EN
        SIN_MUL_ACC = 32'sd3; COS_MUL_ACC = -32'sd4;
        start_sweep(28'd10, 28'd1, 10'd3, 16'd0);
        wait_valid(n);
        SIN_MUL_ACC = -32'sd10; COS_MUL_ACC = 32'sd2;
        wait_valid(n);
        SIN_MUL_ACC = 32'sd6; COS_MUL_ACC = 32'sd6;
        wait_valid(n);
        step();
        check("peak_index", PEAK_INDEX, 64'd1);
        check("peak_mag", PEAK_MAG, 64'd12);
        SIN_MUL_ACC = sin_v; COS_MUL_ACC = cos_v;
`endif

        // Reset during a sweep discards it
        start_sweep(28'd77, 28'd1, 10'd2, 16'd3);
        step();
        RESET_N = 1'b0;
        #2;
        check("mrst_busy", BUSY, 64'd0);
        check("mrst_phase", PHASE_INCREMENT_OUT, 64'd0);
        check("mrst_done", DONE, 64'd0);
        step();
        RESET_N = 1'b1;
        step();
        check("mrst_done_after", DONE, 64'd0);
        check("mrst_idle_after", BUSY, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/frontend_sweep_ctrl.md
FRONTEND_SWEEP_CTRL -- requirements
Module: frontend_sweep_ctrl

Interface
REQ-001 Parameter PHASE_INCREMENT_BITS, default 28, sets the width of the phase-increment values and of the adder that steps them.
REQ-002 Parameter MUL_ACC_WIDTH, default 32, sets the width of the signed sin/cos mul-acc values.
REQ-003 Parameter COUNT_BITS, default 10, sets the width of the point count and the point index.
REQ-004 Parameter SETTLE_BITS, default 16, sets the width of the settle counter.
REQ-005 The ports SHALL be, one per line: name  direction  width  meaning.
- CLK  in  1  single clock; all logic on its rising edge.
- RESET_N  in  1  asynchronous reset, active-low.
- CE  in  1  clock enable; 0 freezes all state, including handshake acceptance.
- START  in  1  starts a sweep when the block is IDLE.
- ABORT  in  1  cancels any sweep in progress.
- CFG_START_INC  in  PHASE_INCREMENT_BITS  phase increment of the first point.
- CFG_STEP_INC  in  PHASE_INCREMENT_BITS  increment added between points.
- CFG_POINTS  in  COUNT_BITS  number of points in the sweep.
- CFG_SETTLE  in  SETTLE_BITS  settle wait per point.
- PHASE_INCREMENT_OUT  out  PHASE_INCREMENT_BITS  drives the frontend PHASE_INCREMENT_IN.
- SIN_MUL_ACC, COS_MUL_ACC  in  MUL_ACC_WIDTH each  filtered results from the frontend, signed.
- RES_VALID  out  1 / RES_READY  in  1  result stream handshake.
- RES_INDEX  out  COUNT_BITS  index of the point being reported.
- RES_PHASE_INC  out  PHASE_INCREMENT_BITS  phase increment used for that point.
- RES_SIN, RES_COS  out  MUL_ACC_WIDTH each  captured sin/cos values.
- BUSY  out  1  high whenever the state is not IDLE.
- DONE  out  1  one-cycle pulse at the normal end of a sweep.
- PEAK_INDEX  out  COUNT_BITS / PEAK_MAG  out  MUL_ACC_WIDTH+1  peak-tracking results (present only with the macro defined).

Function
REQ-006 The FSM states SHALL be IDLE, SETTLE, CAPTURE and OUTPUT, and every transition SHALL occur only on a cycle with CE=1.
REQ-007 IDLE: START=1 with CFG_POINTS!=0 -> latch all CFG_* inputs, set PHASE_INCREMENT_OUT=CFG_START_INC, clear the index, load the settle counter with CFG_SETTLE, and go to SETTLE.
REQ-008 IDLE: START=1 with CFG_POINTS=0 -> pulse DONE the next cycle, stay in IDLE, leave PHASE_INCREMENT_OUT unchanged, and emit no results.
REQ-009 SETTLE: decrement the counter each CE cycle; at 0 go to CAPTURE, so SETTLE lasts exactly CFG_SETTLE+1 CE cycles.
REQ-010 CAPTURE (1 CE cycle): register SIN_MUL_ACC and COS_MUL_ACC into RES_SIN and RES_COS, set RES_INDEX and RES_PHASE_INC, assert RES_VALID, and go to OUTPUT.
REQ-011 OUTPUT: RES_VALID and all RES_* outputs SHALL stay stable until a transfer, defined as RES_VALID & RES_READY & CE.
REQ-012 On a transfer of the last point (index = latched points-1), deassert RES_VALID, pulse DONE for one cycle, go to IDLE, and hold PHASE_INCREMENT_OUT at the last value.
REQ-013 On any other transfer, deassert RES_VALID, increment the index, set PHASE_INCREMENT_OUT += latched step modulo 2^PHASE_INCREMENT_BITS (wrap with no saturation), reload the settle counter, and go to SETTLE.
REQ-014 START while BUSY=1 SHALL be ignored, and changes to CFG_* during a sweep SHALL have no effect.
REQ-015 ABORT=1 with CE=1 in any non-IDLE state -> go to IDLE next cycle with RES_VALID=0 and no DONE pulse; PHASE_INCREMENT_OUT is held.
REQ-016 ABORT SHALL take priority over START and over a simultaneous transfer.
REQ-017 The output latency from a START acceptance to the first RES_VALID SHALL be CFG_SETTLE+2 CE cycles.

Reset
REQ-018 While RESET_N=0, asynchronously, the state SHALL be IDLE and every output and internal register SHALL be zero.
REQ-019 Assertion of RESET_N during a sweep SHALL discard the sweep with no DONE pulse.
REQ-020 After RESET_N is released, the block SHALL first accept START on the first rising edge of CLK.

Configuration
REQ-021 The macro FRONTEND_SWEEP_PEAK_TRACK_EN SHALL control peak tracking.
- Defined: at each CAPTURE, compute mag=|sin|+|cos| (MUL_ACC_WIDTH+1 bits, unsigned).
- Update PEAK_MAG/PEAK_INDEX if mag > PEAK_MAG (strictly greater; the first point always loads).
- Clear both outputs when a sweep is accepted.
- Undefined: the PEAK_* ports and their logic SHALL be absent.

Verification
REQ-022 Basic sweep: START_INC=1000, STEP=10, POINTS=3, SETTLE=4, RES_READY=1 -> three results with indices 0,1,2 and RES_PHASE_INC 1000,1010,1020; first RES_VALID 6 cycles after START; DONE one cycle after the third transfer.
REQ-023 Backpressure: RES_READY=0 for 20 cycles in OUTPUT -> RES_* stable, PHASE_INCREMENT_OUT unchanged, no advance.
REQ-024 Wrap: START_INC=2^28-5, STEP=10, POINTS=2 -> second RES_PHASE_INC=5.
REQ-025 Abort and restart: ABORT in SETTLE of point 1 -> IDLE next cycle, BUSY=0, no DONE; a new START works normally.
REQ-026 Edge cases: POINTS=0 -> DONE pulse and no RES_VALID; CE=0 held for 10 cycles mid-SETTLE -> settle time extended by exactly 10 cycles.
REQ-027 Peak tracking (macro defined): sin/cos captures (3,-4), (-10,2), (6,6) -> PEAK_INDEX=1, PEAK_MAG=12.
